uart_rx_packet_ctrl: RTL and testbench

UART_RX_PACKET_CTRL -- requirements
Module: uart_rx_packet_ctrl

---
 rtl/uart_rx_packet_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_packet_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet_ctrl.sv
// Purpose: UART byte-stream frame parser (SYNC, LEN, payload, CHK), holds good packets for a consumer.
// Latency: outputs registered; pkt_valid and error pulses appear the cycle after the causing rx_done strobe.
// Backpressure: packet held until pkt_valid&&pkt_ready; bytes arriving meanwhile are dropped with err_overrun.
// Optional feature: define PKT_TIMEOUT_EN to enable the inter-byte timeout (err_timeout otherwise tied 0).
module uart_rx_packet_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_byte,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [3:0]  pkt_len,
  output logic [63:0] pkt_data,
  output logic        err_chk,
  output logic        err_len,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic        busy
);

  // Reject out-of-range configurations at elaboration.
  if (MAX_LEN < 1 || MAX_LEN > 8 || TIMEOUT_CYC < 1) begin : g_param_err
    $error("uart_rx_packet_ctrl: MAX_LEN must be 1..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_LEN  = 3'd1,
    GET_DATA = 3'd2,
    GET_CHK  = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t      state, state_nxt;

  // Frame-collection datapath; kept separate from the output registers so
  // pkt_len/pkt_data read zero while a frame is still being assembled.
  logic [3:0]  len_q;
  logic [2:0]  idx_q;
  logic [7:0]  chk_q;
  logic [63:0] data_buf;

  logic        len_ok;
  logic        last_byte;
  logic        chk_match;
  logic        handshake;
  logic        tmo_hit;

  // Decoded per-cycle events feeding the output registers.
  logic        pkt_load;
  logic        err_chk_nxt;
  logic        err_len_nxt;
  logic        err_ovr_nxt;

  assign len_ok    = (rx_byte != 8'd0) && (rx_byte <= 8'(MAX_LEN));
  assign last_byte = (({1'b0, idx_q} + 4'd1) == len_q);
  assign chk_match = (rx_byte == chk_q);
  assign handshake = pkt_valid && pkt_ready;

`ifdef PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          frame_active;

  assign frame_active = (state == GET_LEN) || (state == GET_DATA) || (state == GET_CHK);
  assign tmo_hit      = frame_active && !rx_done && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Count idle cycles inside a frame; any received byte restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (!frame_active || rx_done || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Timeout pulse, registered one cycle after the limit is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= tmo_hit;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_done && rx_byte == SYNC_BYTE) state_nxt = GET_LEN;
      end
      GET_LEN: begin
        if (tmo_hit)      state_nxt = IDLE;
        else if (rx_done) state_nxt = len_ok ? GET_DATA : IDLE;
      end
      GET_DATA: begin
        if (tmo_hit)                   state_nxt = IDLE;
        else if (rx_done && last_byte) state_nxt = GET_CHK;
      end
      GET_CHK: begin
        if (tmo_hit)      state_nxt = IDLE;
        else if (rx_done) state_nxt = chk_match ? HOLD : IDLE;
      end
      HOLD: begin
        // A byte landing on the releasing cycle is treated as an IDLE byte.
        if (handshake) state_nxt = (rx_done && rx_byte == SYNC_BYTE) ? GET_LEN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output event decode.
  always_comb begin
    pkt_load    = 1'b0;
    err_chk_nxt = 1'b0;
    err_len_nxt = 1'b0;
    err_ovr_nxt = 1'b0;
    case (state)
      GET_LEN:  err_len_nxt = rx_done && !len_ok;
      GET_CHK: begin
        pkt_load    = rx_done && chk_match;
        err_chk_nxt = rx_done && !chk_match;
      end
      HOLD:     err_ovr_nxt = rx_done && !handshake;
      default: ;
    endcase
  end

  // Frame collection: length, byte slot index, running checksum, payload buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q    <= 4'd0;
      idx_q    <= 3'd0;
      chk_q    <= 8'd0;
      data_buf <= 64'd0;
    end else if (rx_done && state == GET_LEN && len_ok) begin
      len_q    <= rx_byte[3:0];
      idx_q    <= 3'd0;
      chk_q    <= rx_byte;
      data_buf <= 64'd0;
    end else if (rx_done && state == GET_DATA) begin
      data_buf[{idx_q, 3'b000} +: 8] <= rx_byte;
      chk_q                          <= chk_q ^ rx_byte;
      if (!last_byte) idx_q <= idx_q + 3'd1;
    end
  end

  // Registered outputs: packet capture/hold/clear, error pulses, busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_valid   <= 1'b0;
      pkt_len     <= 4'd0;
      pkt_data    <= 64'd0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
      busy        <= 1'b0;
    end else begin
      err_chk     <= err_chk_nxt;
      err_len     <= err_len_nxt;
      err_overrun <= err_ovr_nxt;
      busy        <= (state_nxt != IDLE);
      if (pkt_load) begin
        pkt_valid <= 1'b1;
        pkt_len   <= len_q;
        pkt_data  <= data_buf;
      end else if (state_nxt != HOLD) begin
        pkt_valid <= 1'b0;
        pkt_len   <= 4'd0;
        pkt_data  <= 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed bench for uart_rx_packet_ctrl: frame parsing, error pulses, hold/overrun, timeout, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge after the capturing rising edge.
// Pulse monitors count error/valid cycles between scenarios.
module tb_uart_rx_packet_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done;
  logic [7:0]  rx_byte;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  pkt_len;
  logic [63:0] pkt_data;
  logic        err_chk;
  logic        err_len;
  logic        err_timeout;
  logic        err_overrun;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Monitor counters, sampled shortly after each rising edge.
  int n_valid = 0;
  int n_chk   = 0;
  int n_len   = 0;
  int n_tmo   = 0;
  int n_ovr   = 0;

  uart_rx_packet_ctrl #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (8),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_done     (rx_done),
    .rx_byte     (rx_byte),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_len     (pkt_len),
    .pkt_data    (pkt_data),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (pkt_valid)   n_valid++;
    if (err_chk)     n_chk++;
    if (err_len)     n_len++;
    if (err_timeout) n_tmo++;
    if (err_overrun) n_ovr++;
  end

  task automatic clear_mon();
    n_valid = 0; n_chk = 0; n_len = 0; n_tmo = 0; n_ovr = 0;
  endtask

  // One-cycle rx_done strobe; returns on the falling edge after it was captured.
  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_done = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_done = 1'b0; rx_byte = 8'h00; pkt_ready = 1'b0;
    idle(3);
    total++; if ({pkt_valid, busy, err_chk, err_len, err_timeout, err_overrun} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {pkt_valid, busy, err_chk, err_len, err_timeout, err_overrun}); end
    total++; if (pkt_len !== 4'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", pkt_len); end
    total++; if (pkt_data !== 64'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", pkt_data); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    clear_mon();
    pkt_ready = 1'b1;
    send(8'hA5);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_after_sync got=%b exp=1", busy); end
    send(8'h03); send(8'h11);
    total++; if (pkt_data !== 64'd0 || pkt_len !== 4'd0) begin
      bad++; $display("FAIL basic_outputs_while_collecting got=%0d/%h exp=0/0", pkt_len, pkt_data); end
    send(8'h22); send(8'h33);
    send(8'h03); // LEN ^ 11 ^ 22 ^ 33 = 03
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", pkt_valid); end
    total++; if (pkt_len !== 4'd3) begin bad++; $display("FAIL basic_len got=%0d exp=3", pkt_len); end
    total++; if (pkt_data !== 64'h0000_0000_0033_2211) begin
      bad++; $display("FAIL basic_data got=%h exp=0000000000332211", pkt_data); end
    @(negedge clk);
    total++; if ({pkt_valid, busy} !== 2'b00 || pkt_len !== 4'd0 || pkt_data !== 64'd0) begin
      bad++; $display("FAIL basic_release got=v%b b%b l%0d d%h exp=all zero", pkt_valid, busy, pkt_len, pkt_data); end
    total++; if (n_valid !== 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d exp=1", n_valid); end
    // Wrong checksum on the same payload must be rejected.
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    total++; if (err_chk !== 1'b1 || pkt_valid !== 1'b0) begin
      bad++; $display("FAIL basic_badchk got=e%b v%b exp=e1 v0", err_chk, pkt_valid); end
    idle(2);
  endtask

  task automatic test_chk_err();
    clear_mon();
    pkt_ready = 1'b1;
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'hFF); // expected 32
    total++; if (err_chk !== 1'b1) begin bad++; $display("FAIL chkerr_pulse got=%b exp=1", err_chk); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL chkerr_busy got=%b exp=0", busy); end
    @(negedge clk);
    total++; if (err_chk !== 1'b0) begin bad++; $display("FAIL chkerr_width got=%b exp=0", err_chk); end
    idle(2);
    total++; if (n_chk !== 1 || n_valid !== 0) begin
      bad++; $display("FAIL chkerr_counts got=chk%0d valid%0d exp=chk1 valid0", n_chk, n_valid); end
  endtask

  task automatic test_len_err();
    clear_mon();
    pkt_ready = 1'b1;
    send(8'hA5); send(8'h00);
    total++; if (err_len !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL len0 got=e%b b%b exp=e1 b0", err_len, busy); end
    send(8'hA5); send(8'h09);
    total++; if (err_len !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL len9 got=e%b b%b exp=e1 b0", err_len, busy); end
    @(negedge clk);
    total++; if (n_len !== 2) begin bad++; $display("FAIL len_pulse_count got=%0d exp=2", n_len); end
    send(8'h5A);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_ignores_byte got=%b exp=0", busy); end
    send(8'hA5); send(8'h01); send(8'hA5); send(8'hA4);
    total++; if (pkt_valid !== 1'b1 || pkt_len !== 4'd1 || pkt_data !== 64'h0000_0000_0000_00A5) begin
      bad++; $display("FAIL sync_as_data got=v%b l%0d d%h exp=v1 l1 d00000000000000a5", pkt_valid, pkt_len, pkt_data); end
    idle(2);
    total++; if (n_chk + n_ovr + n_tmo !== 0) begin
      bad++; $display("FAIL len_no_other_err got=%0d exp=0", n_chk + n_ovr + n_tmo); end
  endtask

  task automatic test_overrun();
    clear_mon();
    pkt_ready = 1'b0;
    send(8'hA5); send(8'h02); send(8'hDE); send(8'hAD); send(8'h71);
    idle(3);
    total++; if (pkt_valid !== 1'b1 || pkt_len !== 4'd2 || pkt_data !== 64'h0000_0000_0000_ADDE) begin
      bad++; $display("FAIL hold_stable got=v%b l%0d d%h exp=v1 l2 d000000000000adde", pkt_valid, pkt_len, pkt_data); end
    send(8'h7E);
    total++; if (err_overrun !== 1'b1 || pkt_data !== 64'h0000_0000_0000_ADDE || pkt_valid !== 1'b1) begin
      bad++; $display("FAIL overrun got=o%b v%b d%h exp=o1 v1 d000000000000adde", err_overrun, pkt_valid, pkt_data); end
    // Release on the same cycle a SYNC byte arrives.
    pkt_ready = 1'b1;
    send(8'hA5);
    pkt_ready = 1'b0;
    total++; if ({pkt_valid, err_overrun, busy} !== 3'b001 || pkt_data !== 64'd0) begin
      bad++; $display("FAIL release_with_sync got=v%b o%b b%b d%h exp=v0 o0 b1 d0", pkt_valid, err_overrun, busy, pkt_data); end
    send(8'h01); send(8'h3C); send(8'h3D);
    total++; if (pkt_valid !== 1'b1 || pkt_data !== 64'h0000_0000_0000_003C) begin
      bad++; $display("FAIL frame_after_release got=v%b d%h exp=v1 d000000000000003c", pkt_valid, pkt_data); end
    pkt_ready = 1'b1;
    idle(2);
    total++; if (n_ovr !== 1) begin bad++; $display("FAIL overrun_count got=%0d exp=1", n_ovr); end
  endtask

  task automatic test_timeout();
    int k;
    clear_mon();
    send(8'hA5); send(8'h04); send(8'h01);
`ifdef PKT_TIMEOUT_EN
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin k = i; break; end
    end
    total++; if (k !== 20) begin bad++; $display("FAIL timeout_cycle got=%0d exp=20", k); end
    @(negedge clk);
    total++; if (err_timeout !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_after got=t%b b%b exp=t0 b0", err_timeout, busy); end
`else
    idle(60);
    total++; if (busy !== 1'b1 || n_tmo !== 0) begin
      bad++; $display("FAIL no_timeout got=b%b t%0d exp=b1 t0", busy, n_tmo); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    clear_mon();
    pkt_ready = 1'b1;
    send(8'hA5); send(8'h03); send(8'h11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if ({pkt_valid, busy, err_chk, err_len, err_timeout, err_overrun} !== 6'b0 || pkt_len !== 4'd0 || pkt_data !== 64'd0) begin
      bad++; $display("FAIL reset_mid got=v%b b%b l%0d d%h exp=all zero", pkt_valid, busy, pkt_len, pkt_data); end
    send(8'hA5); send(8'h02); send(8'h5A); send(8'hA5); send(8'hFD);
    total++; if (pkt_valid !== 1'b1 || pkt_len !== 4'd2 || pkt_data !== 64'h0000_0000_0000_A55A) begin
      bad++; $display("FAIL reset_mid_next got=v%b l%0d d%h exp=v1 l2 d000000000000a55a", pkt_valid, pkt_len, pkt_data); end
    idle(2);
    total++; if (n_chk + n_len + n_ovr + n_tmo !== 0) begin
      bad++; $display("FAIL reset_no_err got=%0d exp=0", n_chk + n_len + n_ovr + n_tmo); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chk_err();
    test_len_err();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
